// File: rtl/qea_pkg.sv
// Shared definitions for the quantum-emulation core: opcodes, header field
// positions, FSM states, complex amplitude type and index helper.
package qea_pkg;

    localparam int CPLX_HALF_W = 32;

    localparam logic [3:0] OP_U  = 4'd0;
    localparam logic [3:0] OP_CU = 4'd1;

    localparam int HDR_OP_LSB  = 60;
    localparam int HDR_TGT_LSB = 48;
    localparam int HDR_CTL_LSB = 40;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_CNT,
        S_FETCH_HDR,
        S_FETCH_COEF,
        S_RD_A,
        S_RD_B,
        S_CALC,
        S_WR_A,
        S_WR_B,
        S_NEXT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic signed [CPLX_HALF_W-1:0] re;
        logic signed [CPLX_HALF_W-1:0] im;
    } cplx_t;

    // Open a gap at bit position pos of v and place b there.
    function automatic logic [31:0] insert_bit(input logic [31:0] v, input logic [5:0] pos,
                                               input logic b);
        logic [31:0] low_mask;
        low_mask = (32'd1 << pos) - 32'd1;
        return ((v & ~low_mask) << 1) | (32'(b) << pos) | (v & low_mask);
    endfunction

endpackage

// File: rtl/qea_cmul.sv
// Combinational complex MAC: y = u0*x0 + u1*x1 in fixed point.
// Final sums wrap, or clamp to the signed range when QEA_SATURATE_EN is defined.
module qea_cmul #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_FRAC_BIT = 30
) (
    input  logic [2*DATA_WIDTH-1:0] u0,
    input  logic [2*DATA_WIDTH-1:0] x0,
    input  logic [2*DATA_WIDTH-1:0] u1,
    input  logic [2*DATA_WIDTH-1:0] x1,
    output logic [2*DATA_WIDTH-1:0] y
);
    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH + 3;

`ifdef QEA_SATURATE_EN
    localparam logic signed [SW-1:0] SAT_MAX = {4'b0000, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {4'b1111, {(DW-1){1'b0}}};
`endif

    // Full-width product, floor-shifted, truncated, then widened for summing.
    function automatic logic signed [SW-1:0] pp(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] full;
        logic signed [2*DW-1:0] scaled;
        full   = $signed(a) * $signed(b);
        scaled = full >>> NUM_FRAC_BIT;
        return SW'(signed'(scaled[DW-1:0]));
    endfunction

    function automatic logic [DW-1:0] clamp_or_wrap(input logic signed [SW-1:0] s);
`ifdef QEA_SATURATE_EN
        if (s > SAT_MAX) return SAT_MAX[DW-1:0];
        if (s < SAT_MIN) return SAT_MIN[DW-1:0];
`endif
        return s[DW-1:0];
    endfunction

    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;

    always_comb begin
        sum_re = pp(u0[2*DW-1:DW], x0[2*DW-1:DW]) - pp(u0[DW-1:0], x0[DW-1:0])
               + pp(u1[2*DW-1:DW], x1[2*DW-1:DW]) - pp(u1[DW-1:0], x1[DW-1:0]);
        sum_im = pp(u0[2*DW-1:DW], x0[DW-1:0]) + pp(u0[DW-1:0], x0[2*DW-1:DW])
               + pp(u1[2*DW-1:DW], x1[DW-1:0]) + pp(u1[DW-1:0], x1[2*DW-1:DW]);
        y      = {clamp_or_wrap(sum_re), clamp_or_wrap(sum_im)};
    end

endmodule

// File: rtl/qea_core.sv
// Quantum-emulation core: applies the gate list in context RAM to the state RAM in place.
// Optional feature macro: QEA_SATURATE_EN (saturating sums in qea_cmul).
module qea_core
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
    parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
    parameter int GATE_ADDR_WIDTH         = 6,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
    input  logic                               i_ctx_en,
    input  logic                               i_ctx_wea,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ctx_addr,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] i_ctx_data,
    input  logic                               i_state_ena,
    input  logic                               i_state_wea,
    input  logic [STATE_ADDR_WIDTH-1:0]        i_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dina,
    output logic                               o_complete,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dout
);
    localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;

    logic [WORD_W-1:0]                  state_ram [2**STATE_ADDR_WIDTH];
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_ram   [2**GATE_CONTEXT_ADDR_WIDTH];

    state_t                             state, next_state;
    logic [MAX_QBIT_WIDTH-1:0]          qbit_num, tgt, ctl;
    logic [3:0]                         op;
    logic [15:0]                        gates_left;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_ptr;
    logic [1:0]                         coef_idx;
    cplx_t                              coef [4];
    cplx_t                              amp_a, amp_b, new_a, new_b;
    logic [31:0]                        pair_k;
    logic [WORD_W/2-1:0]                mac_a, mac_b;

    // Gate decode and pair addressing, all from registered header fields.
    logic        is_ctrl, skip_gate, last_gate, last_pair, ctx_empty;
    logic [5:0]  lo_pos, hi_pos;
    logic [31:0] idx_a, idx_b, pair_last;
    logic [STATE_ADDR_WIDTH-1:0] addr_a, addr_b;
    int          lsb_a, lsb_b;

    assign is_ctrl   = (op == OP_CU);
    assign skip_gate = (tgt >= qbit_num) || (op > OP_CU) ||
                       (is_ctrl && ((ctl >= qbit_num) || (ctl == tgt)));
    assign last_gate = (gates_left == 16'd0);
    assign ctx_empty = (ctx_ram[0][15:0] == 16'd0);
    assign pair_last = (32'd1 << (qbit_num - MAX_QBIT_WIDTH'(1) - MAX_QBIT_WIDTH'(is_ctrl))) - 32'd1;
    assign last_pair = (pair_k == pair_last);
    assign lo_pos    = (tgt < ctl) ? 6'(tgt) : 6'(ctl);
    assign hi_pos    = (tgt < ctl) ? 6'(ctl) : 6'(tgt);
    // Controlled pairs need bit t cleared and bit c set; insert the lower position first.
    assign idx_a     = is_ctrl ? insert_bit(insert_bit(pair_k, lo_pos, lo_pos == 6'(ctl)),
                                            hi_pos, hi_pos == 6'(ctl))
                               : insert_bit(pair_k, 6'(tgt), 1'b0);
    assign idx_b     = idx_a | (32'd1 << tgt);
    assign addr_a    = idx_a[PE_NUM_WIDTH +: STATE_ADDR_WIDTH];
    assign addr_b    = idx_b[PE_NUM_WIDTH +: STATE_ADDR_WIDTH];
    assign lsb_a     = (PE_NUM - 1 - int'(idx_a[PE_NUM_WIDTH-1:0])) * STATE_DATA_WIDTH;
    assign lsb_b     = (PE_NUM - 1 - int'(idx_b[PE_NUM_WIDTH-1:0])) * STATE_DATA_WIDTH;

    qea_cmul #(.DATA_WIDTH(ALU_DATA_WIDTH), .NUM_FRAC_BIT(NUM_FRAC_BIT)) u_cmul_a (
        .u0(coef[0]), .x0(amp_a), .u1(coef[1]), .x1(amp_b), .y(mac_a)
    );
    qea_cmul #(.DATA_WIDTH(ALU_DATA_WIDTH), .NUM_FRAC_BIT(NUM_FRAC_BIT)) u_cmul_b (
        .u0(coef[2]), .x0(amp_a), .u1(coef[3]), .x1(amp_b), .y(mac_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            o_complete   <= 1'b0;
            o_state_dout <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && i_start) o_complete <= 1'b0;
            else if (state == S_DONE)       o_complete <= 1'b1;
            // Read-first: a same-cycle host write lands after this sample.
            if (state == S_IDLE && i_state_ena) o_state_dout <= state_ram[i_state_addra];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:       if (i_start) next_state = S_FETCH_CNT;
            S_FETCH_CNT:  next_state = ctx_empty ? S_DONE : S_FETCH_HDR;
            S_FETCH_HDR:  next_state = S_FETCH_COEF;
            S_FETCH_COEF: if (coef_idx == 2'd3)
                              next_state = !skip_gate ? S_RD_A : (last_gate ? S_DONE : S_FETCH_HDR);
            S_RD_A:       next_state = S_RD_B;
            S_RD_B:       next_state = S_CALC;
            S_CALC:       next_state = S_WR_A;
            S_WR_A:       next_state = S_WR_B;
            S_WR_B:       next_state = S_NEXT;
            S_NEXT:       next_state = !last_pair ? S_RD_A : (last_gate ? S_DONE : S_FETCH_HDR);
            S_DONE:       next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    // NOTE: RAMs and datapath registers carry no reset; the FSM never consumes them before loading.
    always_ff @(posedge clk) begin
        unique case (state)
            S_IDLE:       if (i_start) qbit_num <= i_qbit_num;
            S_FETCH_CNT:  begin
                gates_left <= ctx_ram[0][15:0];
                ctx_ptr    <= GATE_CONTEXT_ADDR_WIDTH'(1);
            end
            S_FETCH_HDR:  begin
                op         <= ctx_ram[ctx_ptr][HDR_OP_LSB  +: 4];
                tgt        <= ctx_ram[ctx_ptr][HDR_TGT_LSB +: MAX_QBIT_WIDTH];
                ctl        <= ctx_ram[ctx_ptr][HDR_CTL_LSB +: MAX_QBIT_WIDTH];
                ctx_ptr    <= ctx_ptr + 1'b1;
                gates_left <= gates_left - 16'd1;
                coef_idx   <= 2'd0;
                pair_k     <= 32'd0;
            end
            S_FETCH_COEF: begin
                coef[coef_idx] <= cplx_t'(ctx_ram[ctx_ptr][GATE_DATA_WIDTH-1:0]);
                ctx_ptr        <= ctx_ptr + 1'b1;
                coef_idx       <= coef_idx + 2'd1;
            end
            S_RD_A:       amp_a <= cplx_t'(state_ram[addr_a][lsb_a +: STATE_DATA_WIDTH]);
            S_RD_B:       amp_b <= cplx_t'(state_ram[addr_b][lsb_b +: STATE_DATA_WIDTH]);
            S_CALC:       begin
                new_a <= cplx_t'(mac_a);
                new_b <= cplx_t'(mac_b);
            end
            S_NEXT:       pair_k <= pair_k + 32'd1;
            default:      ;
        endcase
    end

    // WR_B lands after WR_A, so a pair sharing one word keeps both updates.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            if (i_state_ena && i_state_wea) state_ram[i_state_addra] <= i_state_dina;
            if (i_ctx_en && i_ctx_wea)      ctx_ram[i_ctx_addr]      <= i_ctx_data;
        end else if (state == S_WR_A) begin
            state_ram[addr_a][lsb_a +: STATE_DATA_WIDTH] <= new_a;
        end else if (state == S_WR_B) begin
            state_ram[addr_b][lsb_b +: STATE_DATA_WIDTH] <= new_b;
        end
    end

endmodule

// File: tb/tb_qea_core.sv
// Scoreboard bench for qea_core: a high-level amplitude-array model predicts run
// latency and state contents; a monitor compares every host read against the queue.
module tb_qea_core;

    localparam int N_AMP  = 32;
    localparam int N_WORD = 8;
    localparam logic [63:0] ONE  = 64'h40000000_00000000;
    localparam logic [63:0] HP   = 64'h2D413CCC_00000000;
    localparam logic [63:0] HN   = 64'hD2BEC334_00000000;
    localparam logic [63:0] ZERO = 64'h0;

    typedef struct packed {
        logic [3:0]       op;
        logic [5:0]       t;
        logic [5:0]       c;
        logic [3:0][63:0] u;
    } gate_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [5:0]   i_qbit_num = '0;
    logic         i_ctx_en = 1'b0, i_ctx_wea = 1'b0;
    logic [15:0]  i_ctx_addr = '0;
    logic [63:0]  i_ctx_data = '0;
    logic         i_state_ena = 1'b0, i_state_wea = 1'b0;
    logic [15:0]  i_state_addra = '0;
    logic [255:0] i_state_dina = '0;
    logic         o_complete;
    logic [255:0] o_state_dout;

    int           n_checks = 0;
    int           n_errors = 0;
    int           mre [N_AMP];
    int           mim [N_AMP];
    logic [255:0] exp_q [$];
    gate_t        gates [$];
    logic         rd_issue = 1'b0;

    qea_core dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
        .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr),
        .i_ctx_data(i_ctx_data), .i_state_ena(i_state_ena), .i_state_wea(i_state_wea),
        .i_state_addra(i_state_addra), .i_state_dina(i_state_dina),
        .o_complete(o_complete), .o_state_dout(o_state_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pp(input int a, input int b);
        longint prod;
        prod = longint'(a) * longint'(b);
        return int'(prod >>> 30);
    endfunction

    function automatic int fin(input longint s);
`ifdef QEA_SATURATE_EN
        if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
`endif
        return int'(s);
    endfunction

    function automatic logic [255:0] model_word(input int w);
        logic [255:0] r;
        for (int j = 0; j < 4; j++) r[(3-j)*64 +: 64] = {mre[w*4+j], mim[w*4+j]};
        return r;
    endfunction

    task automatic set_model_word(input int w, input logic [255:0] d);
        for (int j = 0; j < 4; j++) begin
            mre[w*4+j] = int'(d[(3-j)*64+32 +: 32]);
            mim[w*4+j] = int'(d[(3-j)*64 +: 32]);
        end
    endtask

    task automatic model_gate(input gate_t g, input int n, output int cost);
        int op, t, c;
        bit skip;
        op = int'(g.op); t = int'(g.t); c = int'(g.c);
        skip = (t >= n) || (op > 1) || (op == 1 && (c >= n || c == t));
        if (skip) begin
            cost = 5;
            return;
        end
        for (int i = 0; i < (1 << n); i++) begin
            if (((i >> t) & 1) == 0 && (op == 0 || ((i >> c) & 1) == 1)) begin
                int j, ar, ai, br, bi;
                int ur [4];
                int ui [4];
                j = i | (1 << t);
                ar = mre[i]; ai = mim[i]; br = mre[j]; bi = mim[j];
                for (int k = 0; k < 4; k++) begin
                    ur[k] = int'(g.u[k][63:32]);
                    ui[k] = int'(g.u[k][31:0]);
                end
                mre[i] = fin(longint'(pp(ur[0], ar)) - pp(ui[0], ai) + pp(ur[1], br) - pp(ui[1], bi));
                mim[i] = fin(longint'(pp(ur[0], ai)) + pp(ui[0], ar) + pp(ur[1], bi) + pp(ui[1], br));
                mre[j] = fin(longint'(pp(ur[2], ar)) - pp(ui[2], ai) + pp(ur[3], br) - pp(ui[3], bi));
                mim[j] = fin(longint'(pp(ur[2], ai)) + pp(ui[2], ar) + pp(ur[3], bi) + pp(ui[3], br));
            end
        end
        cost = 5 + 6 * ((op == 0) ? (1 << (n - 1)) : (1 << (n - 2)));
    endtask

    function automatic gate_t mk_gate(input int op, input int t, input int c, input logic [63:0] u00,
                                      input logic [63:0] u01, input logic [63:0] u10,
                                      input logic [63:0] u11);
        gate_t g;
        g.op = 4'(op); g.t = 6'(t); g.c = 6'(c);
        g.u[0] = u00; g.u[1] = u01; g.u[2] = u10; g.u[3] = u11;
        return g;
    endfunction

    // ---------------- host-port drivers (enter and leave at negedge) ----------------
    task automatic write_word(input int addr, input logic [255:0] d);
        i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'(addr); i_state_dina = d;
        @(negedge clk);
        i_state_ena = 1'b0; i_state_wea = 1'b0;
    endtask

    task automatic read_word_exp(input int addr, input logic [255:0] exp);
        exp_q.push_back(exp);
        i_state_ena = 1'b1; i_state_wea = 1'b0; i_state_addra = 16'(addr); rd_issue = 1'b1;
        @(negedge clk);
        i_state_ena = 1'b0; rd_issue = 1'b0;
    endtask

    task automatic write_read(input int addr, input logic [255:0] d);
        exp_q.push_back(model_word(addr));
        set_model_word(addr, d);
        i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'(addr);
        i_state_dina = d; rd_issue = 1'b1;
        @(negedge clk);
        i_state_ena = 1'b0; i_state_wea = 1'b0; rd_issue = 1'b0;
    endtask

    task automatic read_all();
        for (int w = 0; w < N_WORD; w++) read_word_exp(w, model_word(w));
    endtask

    task automatic load_state();
        for (int w = 0; w < N_WORD; w++) write_word(w, model_word(w));
    endtask

    task automatic write_ctx(input int addr, input logic [63:0] d);
        i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = 16'(addr); i_ctx_data = d;
        @(negedge clk);
        i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
    endtask

    task automatic load_ctx();
        write_ctx(0, 64'(gates.size()));
        foreach (gates[g]) begin
            write_ctx(1 + 5*g, {gates[g].op, 6'b0, gates[g].t, 2'b0, gates[g].c, 40'b0});
            for (int k = 0; k < 4; k++) write_ctx(2 + 5*g + k, gates[g].u[k]);
        end
    endtask

    task automatic run_dut(input int n, input int exp_lat, input bit intrude);
        int cyc;
        bit done;
        i_qbit_num = 6'(n);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("complete_clear_after_start", o_complete, 0);
        cyc = 0; done = 0;
        while (!done && cyc < exp_lat + 50) begin
            if (intrude && cyc == 3) begin
                i_state_ena = 1'b1; i_state_wea = 1'b1; i_state_addra = 16'd7; i_state_dina = '1;
                i_ctx_en = 1'b1; i_ctx_wea = 1'b1; i_ctx_addr = 16'd6; i_ctx_data = '0;
                i_start = 1'b1;
            end
            if (intrude && cyc == 4) begin
                i_state_ena = 1'b0; i_state_wea = 1'b0; i_ctx_en = 1'b0; i_ctx_wea = 1'b0;
                i_start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (o_complete) done = 1;
        end
        check("run_latency", 256'(cyc), 256'(exp_lat));
        @(negedge clk);
    endtask

    task automatic do_run(input int n, input bit intrude);
        int lat, cost;
        load_ctx();
        lat = 2;
        foreach (gates[g]) begin
            model_gate(gates[g], n, cost);
            lat += cost;
        end
        run_dut(n, lat, intrude);
        read_all();
        check("complete_hold", o_complete, 1);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_AMP; i++) begin
            mre[i] = 0; mim[i] = 0;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic got;
        logic [255:0] exp_w;
        forever begin
            @(posedge clk);
            got = rd_issue;
            #1;
            if (got) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL sb_underflow: read data %h with no expected entry", o_state_dout);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("state_read", o_state_dout, exp_w);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_dout", o_state_dout, 0);
        check("reset_complete", o_complete, 0);

        // Zeroed state reads back zero.
        clear_model();
        load_state();
        read_all();

        // X on qubit 0 moves 1.0 from amp[0] to amp[1].
        mre[0] = 32'h40000000;
        load_state();
        gates.delete();
        gates.push_back(mk_gate(0, 0, 0, ZERO, ONE, ONE, ZERO));
        do_run(5, 0);
        read_word_exp(0, {ZERO, ONE, ZERO, ZERO});

        // Read-first behaviour on a host write.
        write_read(5, {4{32'h12345678, 32'h9ABCDEF0}});
        read_word_exp(5, {4{32'h12345678, 32'h9ABCDEF0}});

        // Hadamard on qubit 0 from |0>.
        clear_model();
        mre[0] = 32'h40000000;
        load_state();
        gates.delete();
        gates.push_back(mk_gate(0, 0, 0, HP, HP, HP, HN));
        do_run(5, 0);
        read_word_exp(0, {HP, HP, ZERO, ZERO});

        // H then CNOT(c=0, t=1), with ignored host writes and start while busy.
        clear_model();
        mre[0] = 32'h40000000;
        load_state();
        gates.delete();
        gates.push_back(mk_gate(0, 0, 0, HP, HP, HP, HN));
        gates.push_back(mk_gate(1, 1, 0, ZERO, ONE, ONE, ZERO));
        do_run(5, 1);
        read_word_exp(0, {HP, ZERO, ZERO, HP});

        // Empty gate list, then a second start clears o_complete.
        gates.delete();
        do_run(5, 0);
        do_run(5, 0);

        // Reset in the middle of a run.
        gates.delete();
        gates.push_back(mk_gate(0, 0, 0, HP, HP, HP, HN));
        gates.push_back(mk_gate(0, 1, 0, HP, HP, HP, HN));
        load_ctx();
        i_qbit_num = 6'd5;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun_reset_complete", o_complete, 0);
        check("midrun_reset_dout", o_state_dout, 0);
        clear_model();
        mre[0] = 32'h40000000;
        load_state();
        do_run(5, 0);

        // Randomized gate lists on random states and qubit counts.
        for (int r = 0; r < 8; r++) begin
            int n, ng;
            n  = int'($urandom_range(2, 5));
            ng = int'($urandom_range(1, 3));
            for (int i = 0; i < N_AMP; i++) begin
                mre[i] = int'($urandom); mim[i] = int'($urandom);
            end
            load_state();
            gates.delete();
            for (int g = 0; g < ng; g++) begin
                int sel, op;
                sel = int'($urandom_range(0, 9));
                op  = (sel < 5) ? 0 : (sel < 9) ? 1 : int'($urandom_range(2, 15));
                gates.push_back(mk_gate(op, int'($urandom_range(0, n)), int'($urandom_range(0, n)),
                                        {$urandom, $urandom}, {$urandom, $urandom},
                                        {$urandom, $urandom}, {$urandom, $urandom}));
            end
            do_run(n, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 256'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
